// File: rtl/encap_tag_parser_pkg.sv
// Shared types and header-layout constants for the encapsulation tag parser.
package nmu_encap_pkg;

   typedef enum logic [1:0] {
      NVGRE   = 2'd0,
      VXLAN   = 2'd1,
      BYPASS2 = 2'd2,
      BYPASS3 = 2'd3
   } encap_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      DONE = 2'd2
   } parse_state_t;

   // Byte offsets relative to the start of the frame / tunnel header.
   localparam int L4_OFFSET     = 34;
   localparam int VX_EXTRA      = 8;
   localparam int VSID_OFFSET   = 4;
   localparam int DA_MAC_OFFSET = 8;
   localparam int DA_MAC_BYTES  = 6;
   localparam int VSID_BYTES    = 4;
   localparam int LANE_BYTES    = 2;

endpackage

// File: rtl/encap_tag_parser_lane_extract.sv
// Pulls LANE_BYTES consecutive header bytes starting at offset_i out of the
// current bus beat. Each byte carries its own present flag, so a lane that
// straddles two beats is picked up half on each beat.
module encap_lane_extract
   import nmu_encap_pkg::*;
#(
   parameter int BUS_WIDTH  = 64,
   parameter int POS_W      = 11,
   parameter int SHIFT      = 3,
   parameter int LANE_BYTES = 2
)(
   input  logic [POS_W-1:0]          offset_i,
   input  logic [POS_W-SHIFT-1:0]    pos_beat_i,
   input  logic [BUS_WIDTH-1:0]      tdata_i,
   output logic [LANE_BYTES*8-1:0]   lane_o,
   output logic [LANE_BYTES-1:0]     present_o
);

   // Byte j of the lane lands in lane_o MSB-first (network order).
   for (genvar j = 0; j < LANE_BYTES; j++) begin : g_byte
      logic [POS_W-1:0] boff;
      assign boff         = offset_i + POS_W'(j);
      assign present_o[j] = (boff[POS_W-1:SHIFT] == pos_beat_i);
      assign lane_o[(LANE_BYTES-1-j)*8 +: 8] = tdata_i[{boff[SHIFT-1:0], 3'b000} +: 8];
   end

endmodule

// File: rtl/encap_tag_parser.sv
// Tunnel VSID + inner destination MAC extraction for NVGRE / VXLAN, with
// per-ID CAM match narrowing route_mask. Stream passes through untouched.
// Optional build macro ENCAP_TAG_PARSER_STATS_EN adds per-ID hit counters.
//
// state | meaning
// IDLE  | waiting for SOP; first beat latches encap mode and parses
// HDR   | collecting VSID / MAC bytes into sticky per-ID match flags
// DONE  | all fields seen; flags frozen until tlast
module encap_tag_parser
   import nmu_encap_pkg::*;
#(
   parameter int AXIS_BUS_WIDTH    = 64,
   parameter int AXIS_ID_WIDTH     = 4,
   parameter int VSID_WIDTH        = 24,
   parameter int MAX_PACKET_LENGTH = 1522,
   parameter int MAX_ADDED_OFFSET  = 64
)(
   input  logic                                     aclk,
   input  logic                                     aresetn,
   input  logic [AXIS_BUS_WIDTH-1:0]                axis_in_tdata,
   input  logic [AXIS_BUS_WIDTH/8-1:0]              axis_in_tkeep,
   input  logic                                     axis_in_tlast,
   input  logic                                     axis_in_tvalid,
   output logic                                     axis_in_tready,
   output logic [AXIS_BUS_WIDTH-1:0]                axis_out_tdata,
   output logic [AXIS_BUS_WIDTH/8-1:0]              axis_out_tkeep,
   output logic                                     axis_out_tlast,
   output logic                                     axis_out_tvalid,
   input  logic                                     axis_out_tready,
   input  logic [(1<<AXIS_ID_WIDTH)-1:0]            route_mask_in,
   input  logic                                     poisoned_in,
   input  logic                                     next_can_have_vsid,
   input  logic [$clog2(MAX_ADDED_OFFSET+1)-1:0]    added_offset,
   input  logic [1:0]                               encap_mode,
   input  logic [(1<<AXIS_ID_WIDTH)*32-1:0]         vsids,
   input  logic [(1<<AXIS_ID_WIDTH)-1:0]            vsid_cam_must_match,
   input  logic [(1<<AXIS_ID_WIDTH)*48-1:0]         mac_encap_addresses,
   input  logic [(1<<AXIS_ID_WIDTH)-1:0]            mac_encap_cam_must_match,
   output logic [(1<<AXIS_ID_WIDTH)-1:0]            route_mask_out,
   output logic                                     poisoned_out,
   output logic                                     parsing_vsid_done,
   output logic                                     truncated
`ifdef ENCAP_TAG_PARSER_STATS_EN
   ,
   input  logic [AXIS_ID_WIDTH-1:0]                 stat_sel,
   input  logic                                     stat_clear,
   output logic [31:0]                              stat_count
`endif
);

   localparam int NUM_IDS = 1 << AXIS_ID_WIDTH;
   localparam int NB      = AXIS_BUS_WIDTH / 8;
   localparam int SHIFT   = $clog2(NB);
   localparam int POS_W   = $clog2(MAX_PACKET_LENGTH + 1);
   localparam logic [31:0] VSID_MASK =
      (VSID_WIDTH >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << VSID_WIDTH) - 64'd1);

   parse_state_t          state_q, state_d;
   encap_mode_t           mode_q, mode_d, mode_eff;
   logic [POS_W-1:0]      pos_q, pos_d;
   logic [POS_W:0]        pos_sum;
   logic [NUM_IDS-1:0]    vflag_q, vflag_d, mflag_q, mflag_d;
   logic [NUM_IDS-1:0]    vhit, mhit;
   logic                  beat, hdr_active, last_mac_present, vsid_ok;
   logic [POS_W-1:0]      base;
   logic [31:0]           vsid_bytes;
   logic [3:0]            vsid_pres;
   logic [47:0]           mac_bytes;
   logic [5:0]            mac_pres;

   assign axis_in_tready  = axis_out_tready;
   assign axis_out_tdata  = axis_in_tdata;
   assign axis_out_tkeep  = axis_in_tkeep;
   assign axis_out_tlast  = axis_in_tlast;
   assign axis_out_tvalid = axis_in_tvalid;

   assign beat       = axis_in_tvalid & axis_out_tready;
   assign hdr_active = (state_q != DONE);
   // The SOP beat must already be parsed with the mode it is about to latch.
   assign mode_eff   = (state_q == IDLE) ? encap_mode_t'(encap_mode) : mode_q;
   assign base       = POS_W'(L4_OFFSET) + POS_W'(added_offset)
                       + ((mode_eff == VXLAN) ? POS_W'(VX_EXTRA) : POS_W'(0));

   for (genvar i = 0; i < 2; i++) begin : g_vsid
      encap_lane_extract #(
         .BUS_WIDTH (AXIS_BUS_WIDTH), .POS_W(POS_W), .SHIFT(SHIFT), .LANE_BYTES(LANE_BYTES)
      ) u_lane (
         .offset_i   (base + POS_W'(VSID_OFFSET + 2*i)),
         .pos_beat_i (pos_q[POS_W-1:SHIFT]),
         .tdata_i    (axis_in_tdata),
         .lane_o     (vsid_bytes[31-16*i -: 16]),
         .present_o  (vsid_pres[2*i +: 2])
      );
   end

   for (genvar i = 0; i < 3; i++) begin : g_mac
      encap_lane_extract #(
         .BUS_WIDTH (AXIS_BUS_WIDTH), .POS_W(POS_W), .SHIFT(SHIFT), .LANE_BYTES(LANE_BYTES)
      ) u_lane (
         .offset_i   (base + POS_W'(DA_MAC_OFFSET + 2*i)),
         .pos_beat_i (pos_q[POS_W-1:SHIFT]),
         .tdata_i    (axis_in_tdata),
         .lane_o     (mac_bytes[47-16*i -: 16]),
         .present_o  (mac_pres[2*i +: 2])
      );
   end

   assign last_mac_present = hdr_active & mac_pres[DA_MAC_BYTES-1];

   // Sticky match flags: start fresh at SOP, AND in every header byte on this beat.
   always_comb begin
      vhit = (state_q == IDLE) ? '1 : vflag_q;
      mhit = (state_q == IDLE) ? '1 : mflag_q;
      if (hdr_active) begin
         for (int k = 0; k < NUM_IDS; k++) begin
            for (int j = 0; j < VSID_BYTES; j++) begin
               if (vsid_pres[j] &&
                   (((vsid_bytes[31-8*j -: 8] ^ vsids[k*32+31-8*j -: 8])
                     & VSID_MASK[31-8*j -: 8]) != 8'h00))
                  vhit[k] = 1'b0;
            end
            for (int j = 0; j < DA_MAC_BYTES; j++) begin
               if (mac_pres[j] &&
                   (mac_bytes[47-8*j -: 8] != mac_encap_addresses[k*48+47-8*j -: 8]))
                  mhit[k] = 1'b0;
            end
         end
      end
   end

   // Beat offset, latched mode and match flags advance only on a handshake.
   always_comb begin
      pos_sum = {1'b0, pos_q} + (POS_W+1)'(NB);
      pos_d   = pos_q;
      mode_d  = mode_q;
      vflag_d = vflag_q;
      mflag_d = mflag_q;
      if (beat) begin
         if (axis_in_tlast)
            pos_d = '0;
         else if (pos_sum > (POS_W+1)'(MAX_PACKET_LENGTH))
            pos_d = POS_W'(MAX_PACKET_LENGTH);
         else
            pos_d = pos_sum[POS_W-1:0];
         if (state_q == IDLE)
            mode_d = encap_mode_t'(encap_mode);
         if (hdr_active) begin
            vflag_d = vhit;
            mflag_d = mhit;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pos_q   <= '0;
         mode_q  <= NVGRE;
         vflag_q <= '1;
         mflag_q <= '1;
      end else begin
         pos_q   <= pos_d;
         mode_q  <= mode_d;
         vflag_q <= vflag_d;
         mflag_q <= mflag_d;
      end
   end

   // FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // FSM next state: tlast always ends the packet, the last MAC byte ends the header.
   always_comb begin
      state_d = state_q;
      if (beat) begin
         unique case (state_q)
            IDLE, HDR: begin
               if (axis_in_tlast)         state_d = IDLE;
               else if (last_mac_present) state_d = DONE;
               else                       state_d = HDR;
            end
            DONE:    if (axis_in_tlast) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM outputs: sideband resolves on the last-MAC beat and holds until tlast.
   always_comb begin
      parsing_vsid_done = last_mac_present | (state_q == DONE);
      truncated         = beat & axis_in_tlast & hdr_active & ~mac_pres[DA_MAC_BYTES-1];
      poisoned_out      = poisoned_in | truncated;
      vsid_ok           = parsing_vsid_done & next_can_have_vsid & ~mode_eff[1];
      if (mode_eff[1])
         route_mask_out = route_mask_in & ~(vsid_cam_must_match | mac_encap_cam_must_match);
      else
         route_mask_out = route_mask_in
                          & (~mac_encap_cam_must_match | mhit)
                          & (~vsid_cam_must_match | (vhit & {NUM_IDS{vsid_ok}}));
   end

`ifdef ENCAP_TAG_PARSER_STATS_EN
   logic [31:0] cnt_q [NUM_IDS];
   logic [31:0] stat_count_q;

   // Per-ID saturating hit counters; a clear beats a same-cycle increment.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int k = 0; k < NUM_IDS; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_IDS; k++) begin
            if (stat_clear)
               cnt_q[k] <= '0;
            else if (beat && axis_in_tlast && !truncated && route_mask_out[k]
                     && (cnt_q[k] != 32'hFFFF_FFFF))
               cnt_q[k] <= cnt_q[k] + 32'd1;
         end
      end
   end

   // Registered readback of the selected counter.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) stat_count_q <= '0;
      else          stat_count_q <= cnt_q[stat_sel];
   end

   assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_encap_tag_parser.sv
// Directed bench for encap_tag_parser: a frame-level model predicts, per
// packet, the beat at which fields resolve, truncation and the route mask.
// Two instances run in lockstep with VSID_WIDTH 24 and 32.
module tb_encap_tag_parser;

   localparam int W   = 64;
   localparam int NID = 16;

   logic            aclk, aresetn;
   logic [W-1:0]    tdata;
   logic [W/8-1:0]  tkeep;
   logic            tlast, tvalid, axis_out_tready;
   logic [15:0]     route_in, vmust, mmust;
   logic            poisoned_in, ncv;
   logic [6:0]      added_offset;
   logic [1:0]      encap_mode;
   logic [NID*32-1:0] vsids_v;
   logic [NID*48-1:0] macs_v;

   logic            rdy_a, rdy_b, ov_a, ov_b, ol_a, ol_b;
   logic [W-1:0]    od_a, od_b;
   logic [W/8-1:0]  ok_a, ok_b;
   logic [15:0]     route24, route32;
   logic            pois24, pois32, done24, done32, trunc24, trunc32;
`ifdef ENCAP_TAG_PARSER_STATS_EN
   logic [3:0]      stat_sel;
   logic            stat_clear;
   logic [31:0]     stat_cnt_a, stat_cnt_b;
   int              model_cnt3;
`endif

   encap_tag_parser #(.VSID_WIDTH(24)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .axis_in_tdata(tdata), .axis_in_tkeep(tkeep), .axis_in_tlast(tlast),
      .axis_in_tvalid(tvalid), .axis_in_tready(rdy_a),
      .axis_out_tdata(od_a), .axis_out_tkeep(ok_a), .axis_out_tlast(ol_a),
      .axis_out_tvalid(ov_a), .axis_out_tready(axis_out_tready),
      .route_mask_in(route_in), .poisoned_in(poisoned_in), .next_can_have_vsid(ncv),
      .added_offset(added_offset), .encap_mode(encap_mode),
      .vsids(vsids_v), .vsid_cam_must_match(vmust),
      .mac_encap_addresses(macs_v), .mac_encap_cam_must_match(mmust),
      .route_mask_out(route24), .poisoned_out(pois24),
      .parsing_vsid_done(done24), .truncated(trunc24)
`ifdef ENCAP_TAG_PARSER_STATS_EN
      , .stat_sel(stat_sel), .stat_clear(stat_clear), .stat_count(stat_cnt_a)
`endif
   );

   encap_tag_parser #(.VSID_WIDTH(32)) dut32 (
      .aclk(aclk), .aresetn(aresetn),
      .axis_in_tdata(tdata), .axis_in_tkeep(tkeep), .axis_in_tlast(tlast),
      .axis_in_tvalid(tvalid), .axis_in_tready(rdy_b),
      .axis_out_tdata(od_b), .axis_out_tkeep(ok_b), .axis_out_tlast(ol_b),
      .axis_out_tvalid(ov_b), .axis_out_tready(axis_out_tready),
      .route_mask_in(route_in), .poisoned_in(poisoned_in), .next_can_have_vsid(ncv),
      .added_offset(added_offset), .encap_mode(encap_mode),
      .vsids(vsids_v), .vsid_cam_must_match(vmust),
      .mac_encap_addresses(macs_v), .mac_encap_cam_must_match(mmust),
      .route_mask_out(route32), .poisoned_out(pois32),
      .parsing_vsid_done(done32), .truncated(trunc32)
`ifdef ENCAP_TAG_PARSER_STATS_EN
      , .stat_sel(stat_sel), .stat_clear(stat_clear), .stat_count(stat_cnt_b)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Model state for the packet in flight.
   logic [7:0]  pkt [0:2047];
   logic [31:0] cam_vsid [NID];
   logic [47:0] cam_mac [NID];
   logic [47:0] mac3 = 48'h02_11_22_33_44_55;
   int          plen, base_m, nbeats, lmac_beat, cur_beat, first_done_beat;
   bit          trunc_pkt, chk_en, got_trunc;
   logic [15:0] exp_route24, exp_route32, got_route24, got_route32;

   function automatic logic [15:0] model_route(input int vw, input int mode);
      logic [31:0] vs, m;
      logic [47:0] mac;
      logic [15:0] vhit, mhit;
      for (int j = 0; j < 4; j++) vs[31-8*j -: 8]  = pkt[base_m+4+j];
      for (int j = 0; j < 6; j++) mac[47-8*j -: 8] = pkt[base_m+8+j];
      m = (vw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << vw) - 32'h1);
      for (int k = 0; k < NID; k++) begin
         vhit[k] = ((vs & m) == (cam_vsid[k] & m));
         mhit[k] = (mac == cam_mac[k]);
      end
      if (mode >= 2) return route_in & ~(vmust | mmust);
      return route_in & (~mmust | mhit) & (~vmust | (ncv ? vhit : 16'h0000));
   endfunction

   task automatic build(input int vx, input int ao, input logic [31:0] vs, input int len);
      int b;
      plen = len;
      for (int i = 0; i < len; i++) pkt[i] = 8'((i * 7 + 1) & 255);
      b = 34 + ao + (vx != 0 ? 8 : 0);
      for (int j = 0; j < 4; j++) pkt[b+4+j] = vs[31-8*j -: 8];
      for (int j = 0; j < 6; j++) pkt[b+8+j] = mac3[47-8*j -: 8];
   endtask

   task automatic send(input int mode, input bit stall, input int abort_at,
                       input int sw_beat, input int sw_mode);
      bit hs;
      int tries;
      base_m          = 34 + int'(added_offset) + (mode == 1 ? 8 : 0);
      nbeats          = (plen + 7) / 8;
      lmac_beat       = (base_m + 13) / 8;
      trunc_pkt       = (lmac_beat > nbeats - 1);
      exp_route24     = model_route(24, mode);
      exp_route32     = model_route(32, mode);
      got_route24     = 16'hDEAD;
      got_route32     = 16'hDEAD;
      got_trunc       = 1'b0;
      first_done_beat = -1;
      encap_mode      = 2'(mode);
      for (int b = 0; b < nbeats; b++) begin
         if (b == abort_at) break;
         if (b == sw_beat) encap_mode = 2'(sw_mode);
         cur_beat = b;
         for (int i = 0; i < 8; i++) begin
            tdata[i*8 +: 8] = (b*8+i < plen) ? pkt[b*8+i] : 8'h00;
            tkeep[i]        = (b*8+i < plen);
         end
         tlast  = (b == nbeats - 1);
         tvalid = 1'b1;
         tries  = 0;
         do begin
            axis_out_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge aclk);
            hs = axis_out_tready;
            @(posedge aclk);
            #1;
            tries++;
         end while (!hs && tries < 64);
         if (!hs) chk("handshake_bound", 32'(tries), 32'(-1));
      end
      tvalid          = 1'b0;
      tlast           = 1'b0;
      axis_out_tready = 1'b1;
   endtask

   // Per-beat comparison of both instances against the frame model.
   always @(negedge aclk) begin : cmp
      bit ed, et;
      if (chk_en && tvalid && axis_out_tready) begin
         ed = !trunc_pkt && (cur_beat >= lmac_beat);
         et = trunc_pkt && (cur_beat == nbeats - 1);
         if (done24 && first_done_beat < 0) first_done_beat = cur_beat;
         chk("done24", 32'(done24), 32'(ed));
         chk("done32", 32'(done32), 32'(ed));
         chk("trunc24", 32'(trunc24), 32'(et));
         chk("trunc32", 32'(trunc32), 32'(et));
         chk("poison24", 32'(pois24), 32'(poisoned_in | et));
         chk("poison32", 32'(pois32), 32'(poisoned_in | et));
         if (ed) begin
            chk("route24", 32'(route24), 32'(exp_route24));
            chk("route32", 32'(route32), 32'(exp_route32));
            got_route24 = route24;
            got_route32 = route32;
         end
         if (trunc24) got_trunc = 1'b1;
`ifdef ENCAP_TAG_PARSER_STATS_EN
         if (tlast && !et && exp_route24[3]) model_cnt3++;
`endif
      end
   end

   initial begin
      aresetn = 1'b0; chk_en = 1'b0;
      tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0; axis_out_tready = 1'b1;
      route_in = 16'hFFFF; vmust = 16'hFFFF; mmust = 16'hFFFF;
      poisoned_in = 1'b0; ncv = 1'b1; added_offset = '0; encap_mode = 2'd0;
      cur_beat = 0; nbeats = 1; lmac_beat = 0; trunc_pkt = 1'b0;
`ifdef ENCAP_TAG_PARSER_STATS_EN
      stat_sel = 4'd3; stat_clear = 1'b0; model_cnt3 = 0;
`endif
      for (int k = 0; k < NID; k++) begin
         cam_vsid[k] = 32'h0000_0100 + 32'(k);
         cam_mac[k]  = 48'h02_00_00_00_00_00 + 48'(k);
      end
      cam_vsid[3] = 32'h00AB_CDEF;
      cam_mac[3]  = mac3;
      for (int k = 0; k < NID; k++) begin
         vsids_v[k*32 +: 32] = cam_vsid[k];
         macs_v[k*48 +: 48]  = cam_mac[k];
      end

      repeat (3) @(posedge aclk);
      #1;
      chk("rst_done", 32'(done24), 32'd0);
      chk("rst_trunc", 32'(trunc24), 32'd0);
      chk("rst_poison", 32'(pois24), 32'd0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      chk_en = 1'b1;

      // 1: NVGRE, VSID at 38-41, resolves on beat 5 (pos 40)
      build(0, 0, 32'h00AB_CDEF, 64);
      send(0, 1'b0, -1, -1, 0);
      chk("t1_route", 32'(got_route24), 32'h0008);
      chk("t1_done_beat", 32'(first_done_beat), 32'd5);

      // 2: VXLAN, added_offset 4, then the same bytes parsed as NVGRE
      added_offset = 7'd4;
      build(1, 4, 32'h00AB_CDEF, 72);
      send(1, 1'b0, -1, -1, 0);
      chk("t2_vxlan_route", 32'(got_route24), 32'h0008);
      send(0, 1'b0, -1, -1, 0);
      chk("t2_as_nvgre_route", 32'(got_route24), 32'h0000);

      // 3: top VSID byte 0xFF is ignored only at VSID_WIDTH 24
      added_offset = 7'd0;
      build(0, 0, 32'hFFAB_CDEF, 64);
      send(0, 1'b0, -1, -1, 0);
      chk("t3_route_w24", 32'(got_route24), 32'h0008);
      chk("t3_route_w32", 32'(got_route32), 32'h0000);

      // 4: 40-byte packet ends mid-VSID, then a normal packet
      build(0, 0, 32'h00AB_CDEF, 40);
      send(0, 1'b0, -1, -1, 0);
      chk("t4_truncated", 32'(got_trunc), 32'd1);
      build(0, 0, 32'h00AB_CDEF, 64);
      send(0, 1'b0, -1, -1, 0);
      chk("t4_after_route", 32'(got_route24), 32'h0008);

      // 5: mode switched to VXLAN during beat 3 applies to the next packet
      send(0, 1'b0, -1, 3, 1);
      chk("t5_cur_route", 32'(got_route24), 32'h0008);
      build(1, 0, 32'h00AB_CDEF, 64);
      send(1, 1'b0, -1, -1, 1);
      chk("t5_next_route", 32'(got_route24), 32'h0008);

      // 6: reset mid-packet, then stalled traffic
      build(0, 0, 32'h00AB_CDEF, 64);
      send(0, 1'b0, 4, -1, 0);
      aresetn = 1'b0;
      #3;
      chk("t6_rst_done", 32'(done24), 32'd0);
`ifdef ENCAP_TAG_PARSER_STATS_EN
      model_cnt3 = 0;
`endif
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      send(0, 1'b1, -1, -1, 0);
      chk("t6_stall_route", 32'(got_route24), 32'h0008);
      added_offset = 7'd4;
      build(1, 4, 32'h00AB_CDEF, 72);
      send(1, 1'b1, -1, -1, 1);
      chk("t6_stall_vx_route", 32'(got_route24), 32'h0008);

      // Bypass and no-tunnel packets with partial must-match sets
      added_offset = 7'd0;
      vmust = 16'h000F; mmust = 16'h0F00;
      build(0, 0, 32'h00AB_CDEF, 64);
      send(2, 1'b0, -1, -1, 2);
      chk("bypass_route", 32'(got_route24), 32'hF0F0);
      ncv = 1'b0;
      send(0, 1'b0, -1, -1, 0);
      ncv = 1'b1;
      vmust = 16'hFFFF; mmust = 16'hFFFF;

      // Poisoned input and a long packet past the position saturation point
      poisoned_in = 1'b1;
      send(0, 1'b1, -1, -1, 0);
      poisoned_in = 1'b0;
      build(0, 0, 32'h00AB_CDEF, 1600);
      send(0, 1'b0, -1, -1, 0);
      chk("long_route", 32'(got_route24), 32'h0008);
      build(0, 0, 32'h00AB_CDEF, 64);
      send(0, 1'b0, -1, -1, 0);
      chk("post_long_route", 32'(got_route24), 32'h0008);

`ifdef ENCAP_TAG_PARSER_STATS_EN
      stat_sel = 4'd3;
      @(posedge aclk);
      #1;
      chk("stat_count3", stat_cnt_a, 32'(model_cnt3));
`endif

      chk_en = 1'b0;
      repeat (2) @(posedge aclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
